// File: rtl/dot_engine_pkg.sv
// Shared types, default widths and result extension for the dot_engine_seq slice.
// DOT_ENGINE_SIGNED_EN selects two's-complement elements and sign-extended results.
package dot_engine_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ELEM_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_ACC_WIDTH  = 24;
    localparam int unsigned DEF_LEN_WIDTH  = 5;
    localparam int unsigned DEF_CNT_WIDTH  = 5;

    localparam int unsigned LANES      = DEF_DATA_WIDTH / DEF_ELEM_WIDTH;
    localparam int unsigned PROD_WIDTH = 2 * DEF_ELEM_WIDTH;
    localparam int unsigned EXT_WIDTH  = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    // Extend the low w bits of v to the full width; fill follows element signedness.
    function automatic logic [EXT_WIDTH-1:0] extend(input logic [EXT_WIDTH-1:0] v,
                                                    input int unsigned w);
        logic [EXT_WIDTH-1:0] keep;
        logic                 fill;
        keep = (EXT_WIDTH'(1) << w) - EXT_WIDTH'(1);
`ifdef DOT_ENGINE_SIGNED_EN
        fill = v[6'(w - 1)];
`else
        fill = 1'b0;
`endif
        return fill ? (v | ~keep) : (v & keep);
    endfunction

endpackage

// File: rtl/dot_engine_seq_if.sv
// Control, status and memory-port bundle between dot_engine_seq and its RAMs/host.
interface dot_engine_seq_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned LEN_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 5
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] cfg_a_base;
    logic [ADDR_WIDTH-1:0] cfg_b_base;
    logic [ADDR_WIDTH-1:0] cfg_r_base;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic [CNT_WIDTH-1:0]  cfg_count;
    logic                  busy;
    logic                  done;
    logic                  a_rd_en;
    logic [ADDR_WIDTH-1:0] a_rd_addr;
    logic [DATA_WIDTH-1:0] a_rd_data;
    logic                  b_rd_en;
    logic [ADDR_WIDTH-1:0] b_rd_addr;
    logic [DATA_WIDTH-1:0] b_rd_data;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    modport master (
        output start, cfg_a_base, cfg_b_base, cfg_r_base, cfg_len, cfg_count,
        output a_rd_data, b_rd_data,
        input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  r_wr_en, r_wr_addr, r_wr_data
    );

    modport slave (
        input  start, cfg_a_base, cfg_b_base, cfg_r_base, cfg_len, cfg_count,
        input  a_rd_data, b_rd_data,
        output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output r_wr_en, r_wr_addr, r_wr_data
    );
endinterface

// File: rtl/dot_lane_mac.sv
// Combinational lane-wise multiply of two packed words plus a sum reduced modulo 2^ACC_WIDTH.
// DOT_ENGINE_SIGNED_EN makes elements and products two's complement.
module dot_lane_mac
    import dot_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  sum_c
);
    localparam int unsigned NUM_LANES = DATA_WIDTH / ELEM_WIDTH;
    localparam int unsigned P_WIDTH   = 2 * ELEM_WIDTH;

`ifdef DOT_ENGINE_SIGNED_EN
    logic signed [P_WIDTH-1:0] prod [NUM_LANES];
`else
    logic        [P_WIDTH-1:0] prod [NUM_LANES];
`endif
    logic [ACC_WIDTH-1:0] part [NUM_LANES+1];

    assign part[0] = '0;

    // Widening the operands first keeps the truncated product exact.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [ELEM_WIDTH-1:0] ea;
        logic [ELEM_WIDTH-1:0] eb;
        assign ea = a[g*ELEM_WIDTH +: ELEM_WIDTH];
        assign eb = b[g*ELEM_WIDTH +: ELEM_WIDTH];
`ifdef DOT_ENGINE_SIGNED_EN
        assign prod[g] = P_WIDTH'($signed(ea)) * P_WIDTH'($signed(eb));
`else
        assign prod[g] = P_WIDTH'(ea) * P_WIDTH'(eb);
`endif
        assign part[g+1] = part[g] + ACC_WIDTH'(prod[g]);
    end

    assign sum_c = part[NUM_LANES];

endmodule

// File: rtl/dot_engine_seq.sv
// Sequencing dot-product engine: streams cfg_count vectors of cfg_len words from two operand RAMs
// and writes one accumulated result per vector. DOT_ENGINE_SIGNED_EN selects signed arithmetic.
module dot_engine_seq
    import dot_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    dot_engine_seq_if.slave bus
);
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  vec_cnt;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  rd_en;
    logic                  valid_d;
    logic                  last_d;
    logic                  drain_cnt;
    logic                  busy_q;
    logic                  done_q;
    logic                  wr_en;
    logic [ACC_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ACC_WIDTH-1:0]  sum_c;
    logic [ACC_WIDTH-1:0]  acc_sum_c;
    logic                  word_last_c;
    logic                  fetch_last_c;
    logic                  cfg_zero_c;

    dot_lane_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ELEM_WIDTH (ELEM_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .a     (bus.a_rd_data),
        .b     (bus.b_rd_data),
        .sum_c (sum_c)
    );

    assign word_last_c  = (word_cnt == len_q - LEN_WIDTH'(1));
    assign fetch_last_c = word_last_c && (vec_cnt == count_q - CNT_WIDTH'(1));
    assign cfg_zero_c   = (bus.cfg_len == '0) || (bus.cfg_count == '0);
    assign acc_sum_c    = acc + sum_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = cfg_zero_c ? ST_FIN : ST_FETCH;
            ST_FETCH: if (fetch_last_c) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt) state_nxt = ST_FIN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Counters, read issue, accumulation and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q     <= '0;
            word_cnt  <= '0;
            count_q   <= '0;
            vec_cnt   <= '0;
            a_addr    <= '0;
            b_addr    <= '0;
            r_ptr     <= '0;
            r_addr    <= '0;
            rd_en     <= 1'b0;
            valid_d   <= 1'b0;
            last_d    <= 1'b0;
            drain_cnt <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en     <= 1'b0;
            acc       <= '0;
            wr_data   <= '0;
        end else begin
            busy_q  <= (state_nxt == ST_FETCH) || (state_nxt == ST_DRAIN);
            done_q  <= (state_nxt == ST_FIN);
            valid_d <= rd_en;
            last_d  <= rd_en && word_last_c;
            wr_en   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        len_q    <= bus.cfg_len;
                        count_q  <= bus.cfg_count;
                        a_addr   <= bus.cfg_a_base;
                        b_addr   <= bus.cfg_b_base;
                        r_ptr    <= bus.cfg_r_base;
                        word_cnt <= '0;
                        vec_cnt  <= '0;
                        acc      <= '0;
                        rd_en    <= !cfg_zero_c;
                    end
                end
                ST_FETCH: begin
                    drain_cnt <= 1'b0;
                    if (fetch_last_c) begin
                        rd_en <= 1'b0;
                    end else begin
                        a_addr <= a_addr + ADDR_WIDTH'(1);
                        b_addr <= b_addr + ADDR_WIDTH'(1);
                        if (word_last_c) begin
                            word_cnt <= '0;
                            vec_cnt  <= vec_cnt + CNT_WIDTH'(1);
                        end else begin
                            word_cnt <= word_cnt + LEN_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: drain_cnt <= 1'b1;
                default: ;
            endcase

            // Data returning this cycle belongs to the word issued one cycle earlier.
            if (valid_d) begin
                if (last_d) begin
                    wr_en   <= 1'b1;
                    r_addr  <= r_ptr;
                    r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                    wr_data <= DATA_WIDTH'(extend(EXT_WIDTH'(acc_sum_c), ACC_WIDTH));
                    acc     <= '0;
                end else begin
                    acc <= acc_sum_c;
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.a_rd_en   = rd_en;
    assign bus.b_rd_en   = rd_en;
    assign bus.a_rd_addr = a_addr;
    assign bus.b_rd_addr = b_addr;
    assign bus.r_wr_en   = wr_en;
    assign bus.r_wr_addr = r_addr;
    assign bus.r_wr_data = wr_data;

endmodule

// File: tb/tb_dot_engine_seq.sv
// Self-checking bench for dot_engine_seq: directed and random jobs against a cycle-level reference model.
// Expected results follow DOT_ENGINE_SIGNED_EN when it is defined for the build.
module tb_dot_engine_seq;
    localparam int unsigned DW    = 32;
    localparam int unsigned EW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned ACCW  = 24;
    localparam int unsigned LW    = 5;
    localparam int unsigned CW    = 5;
    localparam int          DEPTH = 32;
    localparam int          NLANE = 4;

    typedef struct { int cyc; int addr; logic [31:0] data; } wr_ev_t;
    typedef struct { int cyc; int a_addr; int b_addr; bit a_en; bit b_en; } rd_ev_t;
    typedef struct { int a_base; int b_base; int r_base; int len; int count; } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_engine_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

    dot_engine_seq #(
        .DATA_WIDTH(DW), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW),
        .ACC_WIDTH(ACCW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    int          cyc = 0;
    wr_ev_t      wr_obs[$];
    rd_ev_t      rd_obs[$];
    int          done_obs[$];
    bit          busy_obs[int];
    int          n_cmp = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand RAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rd_data <= mem_a[bus.a_rd_addr];
        if (bus.b_rd_en) bus.b_rd_data <= mem_b[bus.b_rd_addr];
    end

    always @(negedge clk) begin
        busy_obs[cyc] = bus.busy;
        if (bus.a_rd_en || bus.b_rd_en)
            rd_obs.push_back('{cyc, int'(bus.a_rd_addr), int'(bus.b_rd_addr), bus.a_rd_en, bus.b_rd_en});
        if (bus.r_wr_en) wr_obs.push_back('{cyc, int'(bus.r_wr_addr), bus.r_wr_data});
        if (bus.done) done_obs.push_back(cyc);
    end

    function automatic longint elem(logic [31:0] w, int i);
        logic [7:0] e;
        e = 8'(w >> (i * 8));
`ifdef DOT_ENGINE_SIGNED_EN
        return longint'($signed(e));
`else
        return longint'(e);
`endif
    endfunction

    // Dot product of vector k, reduced to the accumulator width and extended to a word.
    function automatic logic [31:0] model_vec(job_t j, int k);
        longint acc = 0;
        longint m;
        for (int w = 0; w < j.len; w++) begin
            int idx = k * j.len + w;
            for (int l = 0; l < NLANE; l++)
                acc += elem(mem_a[(j.a_base + idx) % DEPTH], l) * elem(mem_b[(j.b_base + idx) % DEPTH], l);
        end
        m = acc & 64'hFF_FFFF;
`ifdef DOT_ENGINE_SIGNED_EN
        if (m >= 64'h80_0000) m -= 64'h100_0000;
`endif
        return 32'(m);
    endfunction

    task automatic clear_obs();
        wr_obs.delete();
        rd_obs.delete();
        done_obs.delete();
    endtask

    task automatic drive_start(input job_t j, output int s);
        @(negedge clk);
        bus.cfg_a_base = AW'(j.a_base);
        bus.cfg_b_base = AW'(j.b_base);
        bus.cfg_r_base = AW'(j.r_base);
        bus.cfg_len    = LW'(j.len);
        bus.cfg_count  = CW'(j.count);
        bus.start      = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.cfg_a_base = AW'($urandom);
        bus.cfg_b_base = AW'($urandom);
        bus.cfg_r_base = AW'($urandom);
        bus.cfg_len    = LW'($urandom);
        bus.cfg_count  = CW'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_obs.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.cfg_a_base = '0; bus.cfg_b_base = '0; bus.cfg_r_base = '0;
        bus.cfg_len = '0; bus.cfg_count = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.r_wr_en} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.r_wr_en});
        end
        n_cmp++;
        if ({bus.a_rd_addr, bus.b_rd_addr, bus.r_wr_addr, bus.r_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr a=%0d b=%0d r=%0d data=%h expected all 0",
                     bus.a_rd_addr, bus.b_rd_addr, bus.r_wr_addr, bus.r_wr_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dot_jobs();
        for (int n = 0; n < 24; n++) begin
            job_t j;
            int   s, t, nwr, exp_done;
            bit   ok;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] = $urandom;
                mem_b[i] = $urandom;
            end
            case (n)
                0: begin
                    j = '{3, 7, 9, 1, 1};
                    mem_a[3] = 32'h0102_0304; mem_b[7] = 32'h0101_0101;
                end
                1: begin
                    j = '{10, 20, 31, 2, 2};
                    mem_a[10] = 32'h0102_0304; mem_a[11] = 32'h0506_0708;
                    mem_a[12] = 32'h0101_0101; mem_a[13] = 32'h0000_0000;
                    for (int i = 20; i < 24; i++) mem_b[i] = 32'h0101_0101;
                end
                2: begin
                    j = '{0, 5, 4, 1, 1};
                    mem_a[0] = 32'hFFFF_FFFF; mem_b[5] = 32'h0101_0101;
                end
                3: j = '{30, 28, 17, 4, 1};
                default: j = '{int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                               int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
                               int'($urandom_range(0, 4))};
            endcase
            t = j.len * j.count;
            nwr = (t == 0) ? 0 : j.count;
            exp_done = 0;
            clear_obs();
            drive_start(j, s);
            exp_done = (t == 0) ? s + 1 : s + t + 3;
            wait_done(t + 12, ok);

            n_cmp++;
            if (!ok || done_obs.size() != 1 || done_obs[0] != exp_done) begin
                n_fail++;
                $display("FAIL job%0d_done: count=%0d first_cycle=%0d expected one at %0d",
                         n, done_obs.size(), ok ? done_obs[0] - s : -1, exp_done - s);
            end
            n_cmp++;
            if (rd_obs.size() != t) begin
                n_fail++;
                $display("FAIL job%0d_rd_count: got %0d expected %0d", n, rd_obs.size(), t);
            end
            for (int i = 0; i < t && i < rd_obs.size(); i++) begin
                n_cmp++;
                if (rd_obs[i].cyc != s + 1 + i || !rd_obs[i].a_en || !rd_obs[i].b_en ||
                    rd_obs[i].a_addr != (j.a_base + i) % DEPTH || rd_obs[i].b_addr != (j.b_base + i) % DEPTH) begin
                    n_fail++;
                    $display("FAIL job%0d_rd%0d: cyc=S+%0d a=%0d b=%0d en=%b%b expected cyc=S+%0d a=%0d b=%0d en=11",
                             n, i, rd_obs[i].cyc - s, rd_obs[i].a_addr, rd_obs[i].b_addr, rd_obs[i].a_en,
                             rd_obs[i].b_en, 1 + i, (j.a_base + i) % DEPTH, (j.b_base + i) % DEPTH);
                end
            end
            n_cmp++;
            if (wr_obs.size() != nwr) begin
                n_fail++;
                $display("FAIL job%0d_wr_count: got %0d expected %0d", n, wr_obs.size(), nwr);
            end
            for (int k = 0; k < nwr && k < wr_obs.size(); k++) begin
                logic [31:0] exp_d;
                exp_d = model_vec(j, k);
                n_cmp++;
                if (wr_obs[k].cyc != s + 2 + (k + 1) * j.len || wr_obs[k].addr != (j.r_base + k) % DEPTH ||
                    wr_obs[k].data !== exp_d) begin
                    n_fail++;
                    $display("FAIL job%0d_wr%0d: cyc=S+%0d addr=%0d data=%h expected cyc=S+%0d addr=%0d data=%h",
                             n, k, wr_obs[k].cyc - s, wr_obs[k].addr, wr_obs[k].data,
                             2 + (k + 1) * j.len, (j.r_base + k) % DEPTH, exp_d);
                end
            end
            for (int c = s; c <= s + t + 4; c++) begin
                bit exp_b;
                exp_b = (t > 0) && (c >= s + 1) && (c <= s + t + 2);
                n_cmp++;
                if (busy_obs[c] !== exp_b) begin
                    n_fail++;
                    $display("FAIL job%0d_busy: cycle S+%0d got %0b expected %0b", n, c - s, busy_obs[c], exp_b);
                end
            end
            if (wr_obs.size() > 0) begin
                logic [31:0] lit;
                lit = (n == 0) ? 32'd10 : (n == 1) ? 32'd36 :
`ifdef DOT_ENGINE_SIGNED_EN
                      32'hFFFF_FFFC;
`else
                      32'h0000_03FC;
`endif
                if (n <= 2) begin
                    n_cmp++;
                    if (wr_obs[0].data !== lit) begin
                        n_fail++;
                        $display("FAIL job%0d_literal: got %h expected %h", n, wr_obs[0].data, lit);
                    end
                end
                if (n == 1 && wr_obs.size() > 1) begin
                    n_cmp++;
                    if (wr_obs[1].data !== 32'd4 || wr_obs[1].addr != 0) begin
                        n_fail++;
                        $display("FAIL job1_second: data=%h addr=%0d expected 4 at 0", wr_obs[1].data, wr_obs[1].addr);
                    end
                end
            end
            if (n == 3 && rd_obs.size() == 4) begin
                n_cmp++;
                if (rd_obs[0].a_addr != 30 || rd_obs[1].a_addr != 31 || rd_obs[2].a_addr != 0 || rd_obs[3].a_addr != 1) begin
                    n_fail++;
                    $display("FAIL wrap_addr: got %0d %0d %0d %0d expected 30 31 0 1", rd_obs[0].a_addr,
                             rd_obs[1].a_addr, rd_obs[2].a_addr, rd_obs[3].a_addr);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        job_t j, other;
        int   s;
        bit   ok;
        j = '{30, 2, 12, 4, 2};
        other = '{5, 5, 0, 1, 1};
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        clear_obs();
        drive_start(j, s);
        repeat (2) @(negedge clk);
        bus.cfg_a_base = AW'(other.a_base); bus.cfg_r_base = AW'(other.r_base);
        bus.cfg_len = LW'(other.len); bus.cfg_count = CW'(other.count);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(30, ok);
        n_cmp++;
        if (!ok || done_obs.size() != 1 || done_obs[0] != s + 11) begin
            n_fail++;
            $display("FAIL busy_start_done: count=%0d expected one at S+11", done_obs.size());
        end
        n_cmp++;
        if (rd_obs.size() != 8 || wr_obs.size() != 2) begin
            n_fail++;
            $display("FAIL busy_start_counts: reads=%0d writes=%0d expected 8 and 2", rd_obs.size(), wr_obs.size());
        end
        for (int k = 0; k < 2 && k < wr_obs.size(); k++) begin
            n_cmp++;
            if (wr_obs[k].addr != 12 + k || wr_obs[k].data !== model_vec(j, k)) begin
                n_fail++;
                $display("FAIL busy_start_wr%0d: addr=%0d data=%h expected addr=%0d data=%h",
                         k, wr_obs[k].addr, wr_obs[k].data, 12 + k, model_vec(j, k));
            end
        end
    endtask

    task automatic test_zero_cfg();
        job_t jobs [2];
        jobs[0] = '{1, 2, 3, 3, 0};
        jobs[1] = '{4, 5, 6, 0, 3};
        for (int n = 0; n < 2; n++) begin
            int s;
            bit ok;
            clear_obs();
            drive_start(jobs[n], s);
            wait_done(6, ok);
            n_cmp++;
            if (!ok || done_obs.size() != 1 || done_obs[0] != s + 1 || rd_obs.size() != 0 ||
                wr_obs.size() != 0 || busy_obs[s + 1] !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_cfg%0d: dones=%0d at S+%0d reads=%0d writes=%0d busy=%0b expected 1 at S+1, 0, 0, 0",
                         n, done_obs.size(), ok ? done_obs[0] - s : -1, rd_obs.size(), wr_obs.size(), busy_obs[s + 1]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        job_t j;
        int   s;
        j = '{8, 16, 2, 8, 3};
        clear_obs();
        drive_start(j, s);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.r_wr_en} !== 5'b0 ||
            {bus.a_rd_addr, bus.b_rd_addr, bus.r_wr_addr, bus.r_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ctrl=%b a=%0d b=%0d r=%0d data=%h expected all 0",
                     {bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.r_wr_en},
                     bus.a_rd_addr, bus.b_rd_addr, bus.r_wr_addr, bus.r_wr_data);
        end
        rst_n = 1'b1;
        clear_obs();
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rd_obs.size() != 0 || wr_obs.size() != 0 || done_obs.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: reads=%0d writes=%0d dones=%0d expected 0 0 0",
                     rd_obs.size(), wr_obs.size(), done_obs.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_cfg();
        test_start_while_busy();
        test_reset_mid_fetch();
        test_dot_jobs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
